// File: rtl/seg_pipe_stage.sv
// Pipeline segment register between CPU stages: valid/ready handshake with a
// 2-entry skid buffer, stall/flush controls and saturating hazard counters.
module seg_pipe_stage #(
    parameter int unsigned    DW        = 32,
    parameter logic [DW-1:0]  FLUSH_VAL = '0,
    parameter int unsigned    CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   main_q;
    logic [DW-1:0]   skid_q;
    logic            push;
    logic            pop;

    // Saturating add of a small increment (0..2) onto a counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        if (s[CNT_W]) begin
            return '1;
        end
        return s[CNT_W-1:0];
    endfunction

    // Handshake readiness depends only on state, stall and flush (never on out_ready).
    always_comb begin
        in_ready  = (state != FULL) && !stall && !flush;
        out_valid = (state != EMPTY) && !stall && !flush;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    assign out_data  = main_q;
    assign occupancy = 2'(state);

    // Storage, state and counters; priority rst > flush > stall > handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= FLUSH_VAL;
            skid_q    <= FLUSH_VAL;
            stall_cnt <= '0;
            flush_cnt <= '0;
            drop_cnt  <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            main_q    <= FLUSH_VAL;
            skid_q    <= FLUSH_VAL;
            flush_cnt <= sat_add(flush_cnt, 2'd1);
            drop_cnt  <= sat_add(drop_cnt, 2'(state));
        end else if (stall) begin
            stall_cnt <= sat_add(stall_cnt, 2'd1);
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_q <= in_data;
                    end else if (push) begin
                        skid_q <= in_data;
                        state  <= FULL;
                    end else if (pop) begin
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    // Skid entry moves up behind the departing main entry.
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_pipe_stage.sv
// Directed + random bench for seg_pipe_stage with a data scoreboard and
// a small occupancy/counter model; a second 2-bit-counter instance shares stimulus.
module tb_seg_pipe_stage;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          stall;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready,  in_ready2;
    logic          out_valid, out_valid2;
    logic [DW-1:0] out_data,  out_data2;
    logic [1:0]    occupancy, occupancy2;
    logic [15:0]   stall_cnt, flush_cnt, drop_cnt;
    logic [1:0]    stall_cnt2, flush_cnt2, drop_cnt2;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb[$];
    int m_occ;
    int m_stall;
    int m_flush;
    int m_drop;

    seg_pipe_stage #(.DW(DW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .drop_cnt(drop_cnt)
    );

    seg_pipe_stage #(.DW(DW), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2),
        .drop_cnt(drop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] satv(input int v, input int maxv);
        return (v > maxv) ? 32'(maxv) : 32'(v);
    endfunction

    task automatic chk_state();
        chk("occupancy",  32'(occupancy),  32'(m_occ));
        chk("occupancy2", 32'(occupancy2), 32'(m_occ));
        chk("stall_cnt",  32'(stall_cnt),  satv(m_stall, 65535));
        chk("flush_cnt",  32'(flush_cnt),  satv(m_flush, 65535));
        chk("drop_cnt",   32'(drop_cnt),   satv(m_drop, 65535));
        chk("stall_cnt2", 32'(stall_cnt2), satv(m_stall, 3));
        chk("flush_cnt2", 32'(flush_cnt2), satv(m_flush, 3));
        chk("drop_cnt2",  32'(drop_cnt2),  satv(m_drop, 3));
    endtask

    // One clock cycle: drive, check handshake outputs and scoreboard, advance model.
    task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic st, input logic fl);
        logic exp_ir;
        logic exp_ov;
        logic push;
        logic pop;
        logic [DW-1:0] want;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        @(negedge clk);
        exp_ir = (m_occ != 2) && !st && !fl;
        exp_ov = (m_occ != 0) && !st && !fl;
        chk("in_ready",  32'(in_ready),  32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("in_ready2", 32'(in_ready2), 32'(exp_ir));
        push = iv && exp_ir;
        pop  = exp_ov && ordy;
        if (pop) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(1), 32'(0));
            end else begin
                want = sb.pop_front();
                chk("out_data",  out_data,  want);
                chk("out_data2", out_data2, want);
            end
        end
        if (push) sb.push_back(d);
        if (fl) begin
            m_flush++;
            m_drop += m_occ;
            m_occ = 0;
            sb.delete();
        end else if (st) begin
            m_stall++;
        end else begin
            m_occ = m_occ + int'(push) - int'(pop);
        end
        @(posedge clk);
        #1;
        chk_state();
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        m_occ = 0; m_stall = 0; m_flush = 0; m_drop = 0;
        sb.delete();
        chk_state();
        chk("rst_out_data",  out_data, 32'h0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        m_occ = 0; m_stall = 0; m_flush = 0; m_drop = 0;

        // Reset then first beat with 1-cycle latency
        do_reset(2);
        cycle(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
        chk("first_out_data", out_data, 32'hA5A5_0001);
        chk("first_out_valid", 32'(out_valid), 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Fill to FULL under back-pressure; third beat refused
        cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0,  1'b1, 1'b0, 1'b0);
        chk("drained_empty", 32'(sb.size()), 32'd0);

        // Flush FULL with a concurrent input beat
        cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
        chk("flush_out_data", out_data, 32'h0);
        chk("flush_drop", 32'(drop_cnt), 32'd2);

        // Stall with ONE holding 0x44
        cycle(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 32'h66, 1'b1, 1'b1, 1'b0);
        chk("stall_out_data", out_data, 32'h44);
        chk("stall_cnt3", 32'(stall_cnt), 32'd3);
        cycle(1'b1, 32'h66, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0,  1'b1, 1'b0, 1'b0);

        // Stall and flush together: flush wins
        cycle(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h88, 1'b1, 1'b1, 1'b1);
        chk("stflush_stall", 32'(stall_cnt), 32'd3);

        // Streaming throughput with out_ready high
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'(32'h1000 + i), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional stalls
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 1'b0);
        end
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Saturation of the 2-bit counters, then clear by reset
        do_reset(1);
        repeat (6) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("sat_stall2", 32'(stall_cnt2), 32'd3);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 32'hC0 + 32'(k), 1'b0, 1'b0, 1'b0);
            cycle(1'b1, 32'hD0 + 32'(k), 1'b0, 1'b0, 1'b0);
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        chk("sat_drop2", 32'(drop_cnt2), 32'd3);
        chk("drop16", 32'(drop_cnt), 32'd4);
        cycle(1'b1, 32'hE0, 1'b0, 1'b0, 1'b0);
        do_reset(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
